// File: rtl/stream_xbar_credit_ctrl.sv
// Credit-based admission and flush sequencing placed in front of the stream_xbar inputs.
// Define STREAM_XBAR_CREDIT_PERF_EN to build the per-output credit-stall counters.
module stream_xbar_credit_ctrl #(
  parameter int unsigned NumInp     = 2,
  parameter int unsigned NumOut     = 2,
  parameter int unsigned MaxCredits = 4,
  parameter int unsigned SelWidth   = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter int unsigned CntWidth   = $clog2(MaxCredits + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumInp-1:0]               valid_i,
  input  logic [NumInp-1:0][SelWidth-1:0] sel_i,
  output logic [NumInp-1:0]               ready_o,
  output logic [NumInp-1:0]               xbar_valid_o,
  input  logic [NumInp-1:0]               xbar_ready_i,
  input  logic [NumOut-1:0]               credit_i,
  output logic [NumOut-1:0][CntWidth-1:0] credit_cnt_o,
  input  logic                            flush_req_i,
  output logic                            xbar_flush_o,
  output logic                            flush_ack_o,
  output logic                            credit_err_o,
  output logic [NumOut-1:0][31:0]         perf_stall_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxCredits);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [NumInp-1:0]            lock_q, lock_d;
  logic [NumOut-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         armed_q, armed_d;
  logic [NumInp-1:0]            grant;
  logic [NumOut-1:0]            out_grant;
  logic [NumOut-1:0]            wants;
  logic [NumOut-1:0]            admit_ok;

  // Fixed-priority admission: the first unlocked requester per output claims it.
  always_comb begin
    logic hit;
    grant     = '0;
    out_grant = '0;
    wants     = '0;
    admit_ok  = '0;
    hit       = 1'b0;
    for (int j = 0; j < NumOut; j++) begin
      admit_ok[j] = (state_q == IDLE) && (cnt_q[j] != '0);
      for (int i = 0; i < NumInp; i++) begin
        hit = valid_i[i] && !lock_q[i] && (sel_i[i] == SelWidth'(j)) && !wants[j];
        grant[i]     = grant[i] | (hit & admit_ok[j]);
        out_grant[j] = out_grant[j] | (hit & admit_ok[j]);
        wants[j]     = wants[j] | hit;
      end
    end
  end

  // A lock survives until its forwarded valid handshakes with the xbar.
  assign xbar_valid_o = lock_q | grant;
  assign ready_o      = xbar_valid_o & xbar_ready_i;
  assign lock_d       = xbar_valid_o & ~xbar_ready_i;

  // Credits are consumed at grant time; a return into a full counter saturates.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int j = 0; j < NumOut; j++) begin
      case ({out_grant[j], credit_i[j]})
        2'b10: cnt_d[j] = cnt_q[j] - CntWidth'(1);
        2'b01: begin
          if (cnt_q[j] == MaxCnt) begin
            err_d = 1'b1;
          end else begin
            cnt_d[j] = cnt_q[j] + CntWidth'(1);
          end
        end
        default: cnt_d[j] = cnt_q[j];
      endcase
    end
  end

  // Flush sequencer; a request must drop for a cycle before it can re-arm.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~flush_req_i;
    case (state_q)
      IDLE: begin
        if (flush_req_i && armed_q) begin
          state_d = DRAIN;
          armed_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (lock_q == '0) begin
          state_d = FLUSH;
        end else begin
          state_d = DRAIN;
        end
      end
      FLUSH:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
      cnt_q   <= {NumOut{MaxCnt}};
      err_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign credit_cnt_o = cnt_q;
  assign credit_err_o = err_q;
  assign xbar_flush_o = (state_q == FLUSH);
  assign flush_ack_o  = (state_q == ACK);

`ifdef STREAM_XBAR_CREDIT_PERF_EN
  logic [NumOut-1:0][31:0] perf_q;

  // Count cycles where an unlocked request is starved of credit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      for (int j = 0; j < NumOut; j++) begin
        if (wants[j] && (cnt_q[j] == '0)) begin
          perf_q[j] <= perf_q[j] + 32'd1;
        end else begin
          perf_q[j] <= perf_q[j];
        end
      end
    end
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_stream_xbar_credit_ctrl.sv
// Self-checking bench for stream_xbar_credit_ctrl: behavioural credit/flush model plus directed literals.
module tb_stream_xbar_credit_ctrl;

  localparam int NI = 2;
  localparam int NO = 2;
  localparam int MC = 2;
`ifdef STREAM_XBAR_CREDIT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     valid;
  logic [NI-1:0][0:0] sel;
  logic [NI-1:0]     rdy;
  logic [NI-1:0]     xv;
  logic [NI-1:0]     xr;
  logic [NO-1:0]     credit;
  logic [NO-1:0][1:0] cnt;
  logic              freq;
  logic              xflush;
  logic              ack;
  logic              err;
  logic [NO-1:0][31:0] perf;

  stream_xbar_credit_ctrl #(.NumInp(NI), .NumOut(NO), .MaxCredits(MC)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .sel_i(sel), .ready_o(rdy),
    .xbar_valid_o(xv), .xbar_ready_i(xr), .credit_i(credit), .credit_cnt_o(cnt),
    .flush_req_i(freq), .xbar_flush_o(xflush), .flush_ack_o(ack),
    .credit_err_o(err), .perf_stall_o(perf)
  );

  always #5 clk = ~clk;

  // Model: credits per output, pending admitted requests, flush phase.
  int          cred [NO];
  bit          pend [NI];
  bit          gnt  [NI];
  bit          hs   [NI];
  int          phase;  // 0 idle, 1 drain, 2 flush, 3 ack
  bit          armed;
  bit          err_m;
  int unsigned perf_m [NO];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NO; j++) begin
      cred[j] = MC;
      perf_m[j] = 0;
    end
    for (int i = 0; i < NI; i++) begin
      pend[i] = 1'b0;
      hs[i] = 1'b0;
    end
    phase = 0;
    armed = 1'b1;
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    valid = '0; credit = '0; xr = '0; freq = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Settle after the inputs change, derive expectations, compare.
  task automatic settle();
    bit e;
    #3;
    for (int i = 0; i < NI; i++) gnt[i] = 1'b0;
    for (int j = 0; j < NO; j++) begin
      for (int i = 0; i < NI; i++) begin
        if (valid[i] && !pend[i] && (int'(sel[i]) == j)) begin
          if (phase == 0 && cred[j] > 0) gnt[i] = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      e = pend[i] | gnt[i];
      hs[i] = e & xr[i];
      chk("xbar_valid", xv[i], e);
      chk("ready", rdy[i], hs[i]);
    end
    for (int j = 0; j < NO; j++) begin
      chk("credit_cnt", cnt[j], cred[j]);
      chk("perf_stall", perf[j], PERF ? perf_m[j] : 0);
    end
    chk("credit_err", err, err_m);
    chk("xbar_flush", xflush, phase == 2);
    chk("flush_ack", ack, phase == 3);
  endtask

  // Apply this cycle's effects to the model, then step the clock.
  task automatic advance();
    int  taken;
    bit  starving;
    bit  clear;
    clear = 1'b1;
    for (int i = 0; i < NI; i++) if (pend[i]) clear = 1'b0;
    for (int j = 0; j < NO; j++) begin
      taken = 0;
      starving = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (gnt[i] && int'(sel[i]) == j) taken++;
        if (valid[i] && !pend[i] && int'(sel[i]) == j) starving = 1'b1;
      end
      if (starving && cred[j] == 0) perf_m[j]++;
      cred[j] = cred[j] - taken + int'(credit[j]);
      if (cred[j] > MC) begin
        cred[j] = MC;
        err_m = 1'b1;
      end
    end
    case (phase)
      0: if (freq && armed) begin phase = 1; armed = 1'b0; end
         else armed = armed | !freq;
      1: begin if (clear) phase = 2; armed = armed | !freq; end
      2: begin phase = 3; armed = armed | !freq; end
      default: begin phase = 0; armed = armed | !freq; end
    endcase
    for (int i = 0; i < NI; i++) pend[i] = (pend[i] | gnt[i]) & !hs[i];
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  initial begin
    rst = 1'b1; valid = '0; sel = '0; xr = '0; credit = '0; freq = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state.
    settle();
    chk("rst_cnt0", cnt[0], 2);
    chk("rst_cnt1", cnt[1], 2);
    chk("rst_err", err, 0);
    chk("rst_xv", xv, 0);
    advance();

    // Credits run out after two handshakes; one return re-admits.
    valid = 2'b01; sel[0] = 1'b0; xr = 2'b01;
    settle(); chk("c0_xv", xv[0], 1); advance();
    cyc();
    settle(); chk("c2_xv", xv[0], 0); chk("c2_cnt", cnt[0], 0); advance();
    credit = 2'b01;
    settle(); chk("c3_xv", xv[0], 0); advance();
    credit = 2'b00;
    settle(); chk("c4_regrant", xv[0], 1); advance();
    valid = 2'b00; cyc();

    // Two requesters, one credit, stalled xbar.
    do_reset();
    valid = 2'b01; sel[0] = 1'b0; xr = 2'b01; cyc();
    valid = 2'b11; sel[0] = 1'b0; sel[1] = 1'b0; xr = 2'b00;
    for (int k = 0; k < 5; k++) begin
      settle(); chk("stall_xv", xv, 2'b01); advance();
    end
    xr = 2'b01; cyc();
    valid = 2'b00; xr = 2'b00; cyc();

    // Overflow and simultaneous grant plus return.
    do_reset();
    credit = 2'b10; cyc();
    credit = 2'b00;
    settle(); chk("ovf_cnt", cnt[1], 2); chk("ovf_err", err, 1); advance();
    valid = 2'b10; sel[1] = 1'b1; xr = 2'b10; cyc();
    credit = 2'b10; cyc();
    credit = 2'b00; valid = 2'b00; xr = 2'b00;
    settle(); chk("simul_cnt", cnt[1], 1); advance();

    // Flush drains a locked request, then pulses flush and ack.
    do_reset();
    valid = 2'b01; sel[0] = 1'b0; cyc();
    freq = 1'b1; cyc();
    valid = 2'b11; sel[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("drain_nogrant", xv[1], 0); chk("drain_noflush", xflush, 0); advance();
    end
    xr = 2'b01; cyc();
    valid = 2'b10; xr = 2'b00;
    settle(); chk("h1_flush", xflush, 0); advance();
    settle(); chk("h2_flush", xflush, 1); chk("h2_xv1", xv[1], 0); advance();
    settle(); chk("h3_ack", ack, 1); advance();
    settle(); chk("h4_regrant", xv[1], 1); chk("h4_noflush", xflush, 0); advance();
    freq = 1'b0; xr = 2'b10; cyc();
    valid = 2'b00; xr = 2'b00; cyc();

    // Stall counter: 7 starved cycles on output 0.
    do_reset();
    valid = 2'b01; sel[0] = 1'b0; xr = 2'b01;
    for (int k = 0; k < 9; k++) cyc();
    settle(); chk("perf7", perf[0], PERF ? 7 : 0); advance();
    valid = 2'b00; cyc();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int i = 0; i < NI; i++) begin
        if (!valid[i] || hs[i]) begin
          valid[i] = 1'($urandom_range(0, 1));
          sel[i]   = 1'($urandom_range(0, 1));
        end
      end
      xr = 2'($urandom);
      for (int j = 0; j < NO; j++) credit[j] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) freq = ~freq;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_xbar_credit_ctrl.md
Name: stream_xbar_credit_ctrl

Overview:
- Credit-based admission controller placed in front of the `stream_xbar` inputs.
- Tracks per-output downstream buffer credits and forwards an input's valid to the crossbar only once a credit for its selected output is reserved.
- Forwarded valids are held until handshake, so the xbar inputs stay AXI-compliant.
- Sequences crossbar flushes: drain in-flight requests, pulse the xbar flush, acknowledge.

Parameters:
- NumInp, 2, number of requesters (> 0).
- NumOut, 2, number of xbar outputs (> 0).
- MaxCredits, 4, downstream buffer depth per output (> 0); reset value of every credit counter.
- SelWidth, derived = NumOut>1 ? $clog2(NumOut) : 1; do not override.
- CntWidth, derived = $clog2(MaxCredits+1); do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  NumInp  requester valid.
- sel_i  in  NumInp x SelWidth  target output; stable while valid_i is high.
- ready_o  out  NumInp  requester ready.
- xbar_valid_o  out  NumInp  valid to xbar inputs.
- xbar_ready_i  in  NumInp  ready from xbar inputs.
- credit_i  in  NumOut  one-cycle pulse returns one credit for output j.
- credit_cnt_o  out  NumOut x CntWidth  current credit count.
- flush_req_i  in  1  level request to flush the xbar.
- xbar_flush_o  out  1  flush to the xbar arbiters.
- flush_ack_o  out  1  one-cycle pulse when the flush is complete.
- credit_err_o  out  1  sticky credit-overflow flag.
- perf_stall_o  out  NumOut x 32  stall counters (see Optional Feature).

Behaviour:
- Reset (rst_i at clk edge):
  - credit_cnt = MaxCredits; all locks = 0; FSM = IDLE.
  - credit_err_o = 0; xbar_flush_o = 0; flush_ack_o = 0; perf counters = 0.
  - xbar_valid_o and ready_o are 0 in the cycle after reset.
  - Reset mid-transaction drops all locks and reservations without a handshake.
- Per input i, lock bit L[i] marks an admitted request not yet handshaken.
- Admission, per output j, each cycle, in FSM IDLE only:
  - Candidates: inputs with valid_i=1, L=0, sel_i=j.
  - The lowest-index candidate is granted if credit_cnt[j] > 0.
  - At most one grant per output per cycle.
- xbar_valid_o[i] = L[i] | grant[i]. It is combinational and has zero-cycle latency when a credit is available.
- ready_o[i] = xbar_valid_o[i] & xbar_ready_i[i].
- L[i] next = (L[i] | grant[i]) & ~(xbar_valid_o[i] & xbar_ready_i[i]).
- Credit counter update: cnt_next = cnt - grant_to_j + credit_i[j].
  - Credit is consumed at grant time, not at handshake.
  - Simultaneous grant and return leaves the count unchanged.
- Overflow: a return when cnt == MaxCredits with no grant that cycle saturates at MaxCredits and sets credit_err_o. It clears only on reset.
- A grant when cnt == 0 is impossible by construction, so no underflow can occur.
- FSM:
  - IDLE: flush_req_i=1 → DRAIN.
  - DRAIN: no new grants; locked requests complete. When all L=0 → FLUSH.
  - FLUSH: xbar_flush_o=1 for exactly one cycle → ACK.
  - ACK: flush_ack_o=1 for one cycle → IDLE. Admission resumes the next cycle even if flush_req_i is still high.
  - A new flush requires flush_req_i to be low for at least one cycle.
- Credit returns are accepted in all FSM states.
- Credit counters are not changed by a flush.

Optional Feature:
- Macro: STREAM_XBAR_CREDIT_PERF_EN.
- Defined: perf_stall_o[j] counts cycles in which at least one unlocked valid input targets output j while credit_cnt[j] == 0.
  - Counters wrap at 2^32.
  - Reset to 0 by rst_i.
- Undefined: no counter logic is generated; perf_stall_o is tied to 0.

Test Plan (NumInp=2, NumOut=2, MaxCredits=2):
- Reset then idle → credit_cnt_o = {2,2}; all outputs 0; credit_err_o = 0.
- valid_i[0]=1, sel=0, xbar_ready_i=1 for 3 cycles, no returns → handshakes in cycles 0 and 1; cycle 2 xbar_valid_o[0]=0 and credit_cnt[0]=0. Then credit_i[0] pulse → grant the next cycle.
- Both inputs sel=0 in the same cycle, credit=1, xbar_ready_i=0 → only input 0 is forwarded and held stable across 5 stall cycles; input 1 stays blocked.
- credit_i[1] pulse at cnt=2 → cnt stays 2 and credit_err_o=1. Simultaneous grant and return on output 1 at cnt=1 → cnt stays 1.
- Input 0 locked with xbar_ready_i=0, then flush_req_i=1 → DRAIN holds; release ready → xbar_flush_o pulses the cycle after L clears, flush_ack_o follows one cycle later; no grants during DRAIN.
- With STREAM_XBAR_CREDIT_PERF_EN: hold a valid to output 0 at credit 0 for 7 cycles → perf_stall_o[0] = 7. Without the macro → perf_stall_o[0] = 0.
